spi_slave: RTL and testbench

SPI_SLAVE -- requirements
Module: spi_slave

---
 rtl/spi_slave.sv | 97 +++++++++
 tb/tb_spi_slave.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, LENGTH-bit frames, oversampled by CLK.
// SCK/SSEL/MOSI are resynchronised into the CLK domain; all state is CLK-registered.
module spi_slave #(
  parameter int LENGTH = 64
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              SCK,
  input  logic              SSEL,
  input  logic              MOSI,
  input  logic [LENGTH-1:0] TO_SEND,
  output logic [LENGTH-1:0] RECEIVED,
  output logic              RXED,
  output logic              TXED,
  output logic              MISO
);

  localparam int CW = $clog2(LENGTH + 1);

  logic [2:0]        sck_sync;
  logic [2:0]        ssel_sync;
  logic [1:0]        mosi_sync;
  logic [CW-1:0]     bit_cnt;
  logic [LENGTH-1:0] rx_shift;
  logic [LENGTH-1:0] tx_shift;
  logic [LENGTH-1:0] tx_next;
  logic              frame_done;
  logic              sck_rise;
  logic              sck_fall;
  logic              ssel_fall;
  logic              ssel_active;

  // Edge detection on the two oldest synchroniser stages, and next transmit word.
  // MISO is registered from tx_next so it follows the shift in the same CLK,
  // keeping fall-to-MISO latency at two CLK edges after the edge is seen.
  always_comb begin
    sck_rise    = (sck_sync[2:1] == 2'b01);
    sck_fall    = (sck_sync[2:1] == 2'b10);
    ssel_fall   = (ssel_sync[2:1] == 2'b10);
    ssel_active = ~ssel_sync[1];
    tx_next     = tx_shift;
    if (!ssel_active || ssel_fall) begin
      tx_next = TO_SEND;
    end else if (sck_fall) begin
      tx_next = frame_done ? TO_SEND : {tx_shift[LENGTH-2:0], 1'b0};
    end
  end

  // Synchronisers, shift registers, bit counter and completion pulses.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sck_sync   <= '0;
      ssel_sync  <= '0;
      mosi_sync  <= '0;
      bit_cnt    <= '0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      frame_done <= 1'b0;
      RECEIVED   <= '0;
      RXED       <= 1'b0;
      TXED       <= 1'b0;
      MISO       <= 1'b0;
    end else begin
      sck_sync  <= {sck_sync[1:0], SCK};
      ssel_sync <= {ssel_sync[1:0], SSEL};
      mosi_sync <= {mosi_sync[0], MOSI};
      RXED      <= 1'b0;
      TXED      <= 1'b0;
      tx_shift  <= tx_next;
      if (!ssel_active) begin
        bit_cnt    <= '0;
        frame_done <= 1'b0;
        rx_shift   <= '0;
        MISO       <= 1'b0;
      end else begin
        MISO <= tx_next[LENGTH-1];
        if (sck_rise) begin
          rx_shift <= {rx_shift[LENGTH-2:0], mosi_sync[1]};
          if (bit_cnt == CW'(LENGTH - 1)) begin
            RECEIVED   <= {rx_shift[LENGTH-2:0], mosi_sync[1]};
            RXED       <= 1'b1;
            bit_cnt    <= '0;
            frame_done <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + CW'(1);
          end
        end
        // frame_done marks the falling edge that closes the transmitted word
        if (sck_fall && frame_done) begin
          TXED       <= 1'b1;
          frame_done <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_slave.sv
// Randomised bench for spi_slave: an SPI mode-0 master drives frames, a
// scoreboard queue holds the words the slave must report, and a monitor
// pops and compares whenever RXED pulses.
module tb_spi_slave;

  localparam int LENGTH = 64;
  localparam int HALF   = 42;   // ~12 MHz SCK against a 50 MHz CLK

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              SCK = 1'b0;
  logic              SSEL = 1'b1;
  logic              MOSI = 1'b0;
  logic [LENGTH-1:0] TO_SEND = '0;
  logic [LENGTH-1:0] RECEIVED;
  logic              RXED;
  logic              TXED;
  logic              MISO;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned tx_exp  = 0;
  int unsigned tx_seen = 0;
  logic [LENGTH-1:0] exp_q[$];
  logic [LENGTH-1:0] model_rx = '0;

  spi_slave #(.LENGTH(LENGTH)) dut (
    .CLK(CLK), .RESET(RESET), .SCK(SCK), .SSEL(SSEL), .MOSI(MOSI),
    .TO_SEND(TO_SEND), .RECEIVED(RECEIVED), .RXED(RXED), .TXED(TXED), .MISO(MISO)
  );

  always #10 CLK = ~CLK;

  task automatic check(input string name, input logic [LENGTH-1:0] act, input logic [LENGTH-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every RXED pulse must match the oldest outstanding word.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (RXED) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rxed_unexpected: got RECEIVED=%h with no frame outstanding", RECEIVED);
        end else begin
          check("rx_word", RECEIVED, exp_q.pop_front());
        end
      end
      if (TXED) tx_seen++;
    end
  end

  task automatic ssel_low();
    SSEL = 1'b0;
    #200;
  endtask

  task automatic ssel_high();
    #100;
    SSEL = 1'b1;
    #200;
  endtask

  // Clock nbits bits out of w (MSB first); MISO is read at each falling edge.
  // If upd is set, TO_SEND becomes nxt halfway through.
  task automatic shift_bits(input logic [LENGTH-1:0] w, input int nbits, input logic upd,
                            input logic [LENGTH-1:0] nxt, output logic [LENGTH-1:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      MOSI = w[LENGTH-1-i];
      #HALF;
      SCK = 1'b1;
      #HALF;
      got[LENGTH-1-i] = MISO;
      SCK = 1'b0;
      if (upd && i == LENGTH/2) TO_SEND = nxt;
    end
    MOSI = 1'b0;
  endtask

  // One complete frame: the slave must report w and transmit the word it held at frame start.
  task automatic full_frame(input string name, input logic [LENGTH-1:0] w,
                            input logic upd, input logic [LENGTH-1:0] nxt);
    logic [LENGTH-1:0] exp_miso;
    logic [LENGTH-1:0] got;
    exp_miso = TO_SEND;
    exp_q.push_back(w);
    model_rx = w;
    tx_exp++;
    shift_bits(w, LENGTH, upd, nxt, got);
    #100;
    check(name, got, exp_miso);
  endtask

  initial begin
    logic [LENGTH-1:0] got;
    logic [LENGTH-1:0] w;
    logic [LENGTH-1:0] nxt;
    int unsigned nfr;

    repeat (4) @(posedge CLK);
    RESET = 1'b0;
    repeat (6) @(posedge CLK);
    #1;
    check("reset_received", RECEIVED, '0);
    check("reset_miso", LENGTH'(MISO), '0);
    check("reset_pulses", LENGTH'({RXED, TXED}), '0);

    // Scenario 1: single frame with fixed words
    TO_SEND = 64'hDEADBEEF_01234567;
    ssel_low();
    full_frame("s1_miso", 64'hA5A5_0F0F_1234_5678, 1'b0, '0);
    ssel_high();
    check("s1_received", RECEIVED, 64'hA5A5_0F0F_1234_5678);
    check("s1_miso_idle", LENGTH'(MISO), '0);

    // Scenario 2: MSB appears on MISO soon after select, before any SCK
    TO_SEND = 64'h8000_0000_0000_0001;
    @(posedge CLK); #1;
    SSEL = 1'b0;
    repeat (4) @(posedge CLK);
    #1;
    check("s2_miso_msb", LENGTH'(MISO), 64'd1);
    SSEL = 1'b1;
    repeat (5) @(posedge CLK);
    #1;
    check("s2_miso_deselect", LENGTH'(MISO), '0);

    // Scenario 3: aborted 10-bit frame, then a good one
    TO_SEND = 64'h1357_9BDF_2468_ACE0;
    ssel_low();
    shift_bits(64'hFFFF_0000_FFFF_0000, 10, 1'b0, '0, got);
    ssel_high();
    check("s3_received_held", RECEIVED, model_rx);
    ssel_low();
    full_frame("s3_miso", 64'h0123_4567_89AB_CDEF, 1'b0, '0);
    ssel_high();
    check("s3_received", RECEIVED, model_rx);

    // Scenario 4: two frames back-to-back under one select
    TO_SEND = 64'hCAFE_F00D_0000_FFFF;
    ssel_low();
    full_frame("s4_miso_a", 64'h1111_2222_3333_4444, 1'b1, 64'h5A5A_A5A5_C3C3_3C3C);
    full_frame("s4_miso_b", 64'h9999_8888_7777_6666, 1'b0, '0);
    ssel_high();
    check("s4_received", RECEIVED, model_rx);
    check("s4_txed_count", LENGTH'(tx_seen), LENGTH'(tx_exp));

    // Scenario 5: reset mid-frame
    TO_SEND = 64'hFFFF_FFFF_FFFF_FFFF;
    ssel_low();
    shift_bits(64'hF0F0_F0F0_F0F0_F0F0, 20, 1'b0, '0, got);
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    SSEL = 1'b1;
    repeat (2) @(posedge CLK);
    RESET = 1'b0;
    model_rx = '0;
    repeat (6) @(posedge CLK);
    #1;
    check("s5_received", RECEIVED, model_rx);
    check("s5_miso", LENGTH'(MISO), '0);

    // Scenario 6: SCK activity while deselected
    for (int i = 0; i < 20; i++) begin
      MOSI = 1'($urandom);
      #HALF; SCK = 1'b1;
      #HALF; SCK = 1'b0;
    end
    MOSI = 1'b0;
    #100;
    check("s6_received", RECEIVED, model_rx);
    check("s6_miso", LENGTH'(MISO), '0);

    // Random selects, each carrying one or two frames
    for (int k = 0; k < 6; k++) begin
      TO_SEND = {$urandom, $urandom};
      nfr = $urandom_range(1, 2);
      ssel_low();
      for (int f = 0; f < int'(nfr); f++) begin
        w   = {$urandom, $urandom};
        nxt = {$urandom, $urandom};
        full_frame("rand_miso", w, 1'b1, nxt);
      end
      ssel_high();
      check("rand_received", RECEIVED, model_rx);
    end

    #200;
    check("rx_outstanding", LENGTH'(exp_q.size()), '0);
    check("txed_total", LENGTH'(tx_seen), LENGTH'(tx_exp));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
